adpll_lock_monitor: RTL and testbench

- Parametrised lock detector for an N-node ADPLL mesh.
- Each node's signed phase-detector error is sampled on its own strobe and fed to a per-node three-state lock FSM with hysteresis.
- Reports per-node and aggregate lock, a sticky loss-of-lock flag, and per-node peak error magnitude.
- Exposes a selectable channel for the 7-segment display path; sits beside the NetworkADPLL array in the test top, on the ADPLL fabric clock.

---
 rtl/adpll_lock_monitor.sv | 129 ++++++++++++
 tb/tb_adpll_lock_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_monitor.sv
// adpll_lock_monitor: per-node hysteretic lock FSMs with sticky loss and peak phase-error tracking
module adpll_lock_monitor #(
  parameter int NODES         = 4,
  parameter int PDET_WIDTH    = 8,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOCK_COUNT    = 512,
  parameter int LOSS_COUNT    = 4,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [NODES-1:0]            sample_i,
  input  logic [NODES*PDET_WIDTH-1:0] error_i,
  input  logic [SEL_WIDTH-1:0]        sel_i,
  output logic [NODES-1:0]            locked_o,
  output logic                        all_locked_o,
  output logic                        any_lost_o,
  output logic [1:0]                  sel_state_o,
  output logic [PDET_WIDTH-1:0]       sel_peak_o
);
  localparam int AW = LOCK_COUNT > 1 ? $clog2(LOCK_COUNT) : 1;
  localparam int MW = LOSS_COUNT > 1 ? $clog2(LOSS_COUNT) : 1;
  localparam int SN = 2 ** SEL_WIDTH;
  localparam logic [1:0] UNLOCKED = 2'b00, ACQUIRE = 2'b01, LOCKED = 2'b10;
  localparam logic [PDET_WIDTH-1:0] LT = PDET_WIDTH'(LOCK_THRESH);
  localparam logic [PDET_WIDTH-1:0] UT = PDET_WIDTH'(UNLOCK_THRESH);
  localparam logic [AW-1:0] ACQ_LAST = AW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_COUNT - 1);
  logic [SN-1:0][1:0]            state;
  logic [SN-1:0][PDET_WIDTH-1:0] peak;
  logic [NODES-1:0]              lost;
  genvar k;
  generate
    for (k = 0; k < SN; k++) begin : g_node
      if (k < NODES) begin : g_live
        logic [PDET_WIDTH-1:0] err, mag, pk;
        logic [1:0]            st, st_nx;
        logic [AW-1:0]         acq, acq_nx;
        logic [MW-1:0]         miss, miss_nx;
        logic                  qual, miss_hit, loss, lost_q;
        assign err      = error_i[k*PDET_WIDTH +: PDET_WIDTH];
        assign mag      = err[PDET_WIDTH-1] ? -err : err;
        assign qual     = mag <= LT;
        assign miss_hit = mag > UT;
        // state and hysteresis counters
        always_ff @(posedge fpga_clk_i or posedge reset_i)
          if (reset_i) begin
            st   <= UNLOCKED;
            acq  <= '0;
            miss <= '0;
          end else begin
            st   <= st_nx;
            acq  <= acq_nx;
            miss <= miss_nx;
          end
        // lock FSM transitions, evaluated only on an enabled strobe
        always_comb begin
          st_nx   = st;
          acq_nx  = acq;
          miss_nx = miss;
          loss    = 1'b0;
          if (!enable_i) begin
            st_nx   = UNLOCKED;
            acq_nx  = '0;
            miss_nx = '0;
          end else if (sample_i[k])
            case (st)
              UNLOCKED:
                if (qual) begin
                  st_nx   = LOCK_COUNT == 1 ? LOCKED : ACQUIRE;
                  acq_nx  = LOCK_COUNT == 1 ? '0 : AW'(1);
                  miss_nx = '0;
                end
              ACQUIRE:
                if (!qual) begin
                  st_nx  = UNLOCKED;
                  acq_nx = '0;
                end else if (acq == ACQ_LAST) begin
                  st_nx   = LOCKED;
                  acq_nx  = '0;
                  miss_nx = '0;
                end else
                  acq_nx = acq + 1'b1;
              LOCKED:
                if (!miss_hit)
                  miss_nx = '0;
                else if (miss == MISS_LAST) begin
                  st_nx   = UNLOCKED;
                  miss_nx = '0;
                  loss    = 1'b1;
                end else
                  miss_nx = miss + 1'b1;
              default: st_nx = UNLOCKED;
            endcase
        end
        // peak magnitude and sticky loss; clear wins over same-cycle updates
        always_ff @(posedge fpga_clk_i or posedge reset_i)
          if (reset_i) begin
            pk     <= '0;
            lost_q <= 1'b0;
          end else begin
            pk     <= clear_i ? '0 : (sample_i[k] && mag > pk) ? mag : pk;
            lost_q <= !clear_i && (lost_q || loss);
          end
        assign state[k] = st;
        assign peak[k]  = pk;
        assign lost[k]  = lost_q;
      end else begin : g_pad
        assign state[k] = UNLOCKED;
        assign peak[k]  = '0;
      end
    end
  endgenerate
  // registered aggregate of sticky loss bits
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i) any_lost_o <= 1'b0;
    else any_lost_o <= |lost;
  // lock flags and display channel decode
  always_comb begin
    locked_o = '0;
    for (int i = 0; i < NODES; i++) locked_o[i] = state[i] == LOCKED;
    sel_state_o = state[sel_i];
    sel_peak_o  = peak[sel_i];
  end
  assign all_locked_o = &locked_o;
endmodule

// File: tb/tb_adpll_lock_monitor.sv
// tb_adpll_lock_monitor: scoreboard bench with a reference lock model and directed plan checks
module tb_adpll_lock_monitor;
  localparam int N = 4, W = 8, LC = 8, LS = 3, LT = 4, UT = 16;
  logic clk = 0, rst = 1, en = 0, clr = 0;
  logic [N-1:0] smp = '0;
  logic [N*W-1:0] err = '0;
  logic [1:0] sel = '0;
  logic [N-1:0] locked;
  logic all_locked, any_lost;
  logic [1:0] sel_state;
  logic [W-1:0] sel_peak;
  adpll_lock_monitor #(.NODES(N), .PDET_WIDTH(W), .LOCK_THRESH(LT), .UNLOCK_THRESH(UT),
                       .LOCK_COUNT(LC), .LOSS_COUNT(LS), .SEL_WIDTH(2)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .clear_i(clr), .sample_i(smp),
    .error_i(err), .sel_i(sel), .locked_o(locked), .all_locked_o(all_locked),
    .any_lost_o(any_lost), .sel_state_o(sel_state), .sel_peak_o(sel_peak));
  always #5 clk = ~clk;
  typedef struct {string tag; int sig; int due; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  int ms[N], acq[N], miss[N], pk[N];
  bit lost[N];
  bit anyl;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask
  function automatic logic [31:0] observe(int sig);
    case (sig)
      0: return 32'(locked);
      1: return 32'(all_locked);
      2: return 32'(any_lost);
      3: return 32'(sel_state);
      default: return 32'(sel_peak);
    endcase
  endfunction
  task automatic push(string tag, int sig, int d, logic [31:0] exp);
    sb.push_back('{tag, sig, cyc_n + d, exp});
  endtask
  task automatic cyc();
    exp_t keep[$];
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.due <= cyc_n) check(e.tag, observe(e.sig), e.exp);
      else keep.push_back(e);
    end
    sb = keep;
  endtask
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      ms[k] = 0; acq[k] = 0; miss[k] = 0; pk[k] = 0; lost[k] = 0;
    end
    anyl = 0;
  endtask
  function automatic logic [N*W-1:0] e4(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  task automatic step(bit e_, bit c_, logic [N-1:0] s_, logic [N*W-1:0] r_, logic [1:0] sl);
    bit ol;
    bit ev;
    int v, m;
    logic [N-1:0] lv;
    en = e_; clr = c_; smp = s_; err = r_; sel = sl;
    ol = 0;
    for (int k = 0; k < N; k++) ol |= lost[k];
    for (int k = 0; k < N; k++) begin
      v = $signed(r_[k*W +: W]);
      m = v < 0 ? -v : v;
      if (c_) pk[k] = 0;
      else if (s_[k] && m > pk[k]) pk[k] = m;
      ev = 0;
      if (!e_) begin
        ms[k] = 0; acq[k] = 0; miss[k] = 0;
      end else if (s_[k]) begin
        if (ms[k] == 0) begin
          if (m <= LT) begin ms[k] = 1; acq[k] = 1; end
        end else if (ms[k] == 1) begin
          if (m > LT) begin ms[k] = 0; acq[k] = 0; end
          else if (acq[k] == LC - 1) begin ms[k] = 2; acq[k] = 0; miss[k] = 0; end
          else acq[k]++;
        end else begin
          if (m > UT) begin
            miss[k]++;
            if (miss[k] == LS) begin ms[k] = 0; miss[k] = 0; ev = 1; end
          end else miss[k] = 0;
        end
      end
      if (c_) lost[k] = 0;
      else if (ev) lost[k] = 1;
    end
    anyl = ol;
    for (int k = 0; k < N; k++) lv[k] = ms[k] == 2;
    push("m_locked", 0, 1, 32'(lv));
    push("m_all_locked", 1, 1, 32'(&lv));
    push("m_any_lost", 2, 1, 32'(anyl));
    push("m_sel_state", 3, 1, 32'(ms[sl]));
    push("m_sel_peak", 4, 1, 32'(pk[sl]));
    cyc();
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1; en = 0; clr = 0; smp = '0;
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_all_locked", 32'(all_locked), 0);
    check("rst_any_lost", 32'(any_lost), 0);
    check("rst_sel_state", 32'(sel_state), 0);
    check("rst_sel_peak", 32'(sel_peak), 0);
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    int r;
    logic [N*W-1:0] rv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int s = 0; s < 4; s++) begin
      push("idle_state", 3, 1, 0);
      step(0, 0, '0, '0, 2'(s));
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push("acq7_state", 3, 1, 1);
      if (i == 7) push("lock8", 0, 1, 4'b0001);
      step(1, 0, 4'b0001, e4(3, 0, 0, 0), 0);
    end
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 4'b0001, e4(3, 0, 0, 0), 0);
    push("drop_on_5", 3, 1, 0);
    step(1, 0, 4'b0001, e4(5, 0, 0, 0), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push("lock_neg4", 0, 1, 4'b0001);
      step(1, 0, 4'b0001, e4(-4, 0, 0, 0), 0);
    end
    begin
      int seq[6] = '{17, 17, 10, 17, 17, 17};
      for (int i = 0; i < 6; i++) begin
        if (i < 5) push("hold_locked", 0, 1, 4'b0001);
        if (i == 5) begin
          push("lost_unlock", 0, 1, 0);
          push("any_lost_lag", 2, 1, 0);
          push("any_lost_set", 2, 2, 1);
        end
        step(1, 0, 4'b0001, e4(seq[i], 0, 0, 0), 0);
      end
      step(1, 0, '0, '0, 0);
    end
    push("peak_80", 4, 1, 8'h80);
    step(1, 0, 4'b0100, e4(0, 0, -128, 0), 2);
    push("peak_held", 4, 1, 8'h80);
    step(1, 0, 4'b0100, e4(0, 0, 5, 0), 2);
    push("peak_clear", 4, 1, 0);
    push("any_lost_clr", 2, 2, 0);
    step(1, 1, 4'b0100, e4(0, 0, 127, 0), 2);
    step(1, 0, '0, '0, 2);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push("all7", 1, 1, 0);
      if (i == 7) push("all8", 1, 1, 1);
      step(1, 0, 4'b1111, e4(0, 1, -2, 4), 3);
    end
    push("dis_locked", 0, 1, 0);
    push("dis_all", 1, 1, 0);
    push("dis_any_lost", 2, 1, 0);
    step(0, 0, 4'b1111, e4(0, 1, -2, 4), 3);
    for (int i = 0; i < 5; i++) step(1, 0, 4'b0010, e4(0, 2, 0, 0), 1);
    do_reset();
    push("post_rst_n1", 3, 1, 0);
    step(1, 0, '0, '0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push("n1_acq7", 3, 1, 1);
      if (i == 7) push("n1_lock", 0, 1, 4'b0010);
      step(1, 0, 4'b0010, e4(0, -1, 0, 0), 1);
    end
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++) begin
        r = $urandom_range(0, 99);
        rv[k*W +: W] = r < 80 ? 8'($signed($urandom_range(0, 8)) - 4) :
                       r < 92 ? 8'($urandom_range(17, 40)) * ((r & 1) != 0 ? -8'sd1 : 8'sd1) :
                       8'($urandom);
      end
      step($urandom_range(0, 29) != 0, $urandom_range(0, 59) == 0, 4'($urandom), rv, 2'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
